// File: rtl/pixel_line_fetcher_pkg.sv
// Shared types and constants for the LED panel line fetcher.
// FSM encodings, RGB565 field widths, panel geometry, ppr clamp.
package pixel_line_fetcher_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } fsm_state_t;

  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int RGB565_W = RGB_R_W + RGB_G_W + RGB_B_W;

  localparam int HALF_ROWS_DEF = 32;

  function automatic logic [9:0] clamp_ppr(
    input logic [9:0] p,
    input int         max_p
  );
    if (int'(p) > max_p) return 10'(max_p);
    return p;
  endfunction

endpackage

// File: rtl/pixel_line_fetcher_fifo.sv
// pixel_pair_fifo: synchronous first-word-fall-through pair buffer.
// Ports: push/push_data in, pop in, pop_data/valid/count out.
module pixel_pair_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid    = (count != '0);
  assign do_push  = push && (count != CW'(DEPTH));
  assign do_pop   = pop && valid;
  assign pop_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_line_fetcher.sv
// Fetches upper/lower row pair from frame buffer, streams pixel pairs.
// Ports: line control in, arbiter read port, pair stream out, status.
module pixel_line_fetcher
  import pixel_line_fetcher_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 15,
  parameter int DATA_WIDTH    = RGB565_W,
  parameter int MAX_PIXELS    = 512,
  parameter int HALF_ROWS     = HALF_ROWS_DEF,
  parameter int FB_OFFSET     = 0,
  parameter int PAIR_DEPTH    = 8
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      line_start,
  input  logic [4:0]                line_index,
  input  logic                      frame_buffer_select,
  input  logic [9:0]                pixels_per_row,
  output logic [ADDRESS_WIDTH-1:0]  address_mem,
  output logic                      wr_mem,
  output logic                      req_mem,
  input  logic                      fifo_full_mem,
  input  logic [DATA_WIDTH-1:0]     data_in_mem,
  input  logic                      data_in_ready_mem,
  output logic [2*DATA_WIDTH-1:0]   pix_data,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic                      busy,
  output logic                      line_done,
  output logic                      start_ignored
);

  localparam int AW   = ADDRESS_WIDTH;
  localparam int CRW  = $clog2(2 * PAIR_DEPTH + 1);
  localparam int CNTW = $clog2(PAIR_DEPTH + 1);

  fsm_state_t state;

  logic [9:0]    ppr_q;
  logic [AW-1:0] base_up;
  logic [AW-1:0] base_lo;
  logic [9:0]    col;
  logic          half;
  logic          all_issued;
  logic [CRW-1:0] credits;
  logic          word_sel;
  logic [DATA_WIDTH-1:0] upper_hold;
  logic [9:0]    pairs_rx;
  logic [CNTW-1:0] fifo_count;

  // Address math is done mod 2^AW throughout; wrap is intended.
  logic [9:0]    ppr_in;
  logic [AW-1:0] off_in;
  logic [AW-1:0] base_up_in;
  logic [AW-1:0] base_lo_in;
  logic [AW-1:0] next_addr;

  assign ppr_in = clamp_ppr(pixels_per_row, MAX_PIXELS);
  assign off_in = frame_buffer_select ? AW'(FB_OFFSET) : '0;
  assign base_up_in = off_in
    + AW'(line_index) * AW'(ppr_in);
  assign base_lo_in = off_in
    + (AW'(line_index) + AW'(HALF_ROWS)) * AW'(ppr_in);
  assign next_addr = (half ? base_lo : base_up) + AW'(col);

  logic          accept;
  logic          pop;
  logic          push;
  logic          rx_active;
  logic [CRW:0]  cred_nx;
  logic [CRW:0]  need;
  logic          slot_free;
  logic          can_issue;
  logic          last_req;
  logic          drain_ok;

  assign wr_mem    = 1'b0;
  assign accept    = req_mem & ~fifo_full_mem;
  assign pop       = pix_valid & pix_ready;
  assign rx_active = (state == S_FETCH) | (state == S_DRAIN);
  assign push      = rx_active & data_in_ready_mem & word_sel;

  // Credits as they will stand after this edge; a new request is
  // only presented when it is already covered by those credits.
  assign cred_nx = {1'b0, credits}
    - {{CRW{1'b0}}, accept}
    + (pop ? (CRW+1)'(2) : '0);
  // An upper request reserves room for its lower partner too.
  assign need      = half ? (CRW+1)'(1) : (CRW+1)'(2);
  assign slot_free = ~req_mem | accept;
  assign can_issue = (state == S_FETCH) & ~all_issued
    & slot_free & (cred_nx >= need);
  assign last_req  = half & (col == ppr_q - 10'd1);
  assign drain_ok  = (pairs_rx == ppr_q)
    & ((fifo_count == '0)
       | ((fifo_count == CNTW'(1)) & pop));

  pixel_pair_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (PAIR_DEPTH)
  ) u_fifo (
    .clk       (clk_sys),
    .rst       (reset),
    .push      (push),
    .push_data ({upper_hold, data_in_mem}),
    .pop       (pop),
    .pop_data  (pix_data),
    .valid     (pix_valid),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      ppr_q         <= '0;
      base_up       <= '0;
      base_lo       <= '0;
      col           <= '0;
      half          <= 1'b0;
      all_issued    <= 1'b0;
      credits       <= CRW'(2 * PAIR_DEPTH);
      word_sel      <= 1'b0;
      upper_hold    <= '0;
      pairs_rx      <= '0;
      req_mem       <= 1'b0;
      address_mem   <= '0;
      busy          <= 1'b0;
      line_done     <= 1'b0;
      start_ignored <= 1'b0;
    end else begin
      line_done     <= 1'b0;
      start_ignored <= line_start & (state != S_IDLE);
      credits       <= cred_nx[CRW-1:0];

      if (can_issue) begin
        req_mem     <= 1'b1;
        address_mem <= next_addr;
        half        <= ~half;
        if (half) col <= col + 10'd1;
        if (last_req) all_issued <= 1'b1;
      end else if (accept) begin
        req_mem <= 1'b0;
      end

      if (rx_active && data_in_ready_mem) begin
        word_sel <= ~word_sel;
        if (!word_sel) upper_hold <= data_in_mem;
        else pairs_rx <= pairs_rx + 10'd1;
      end

      unique case (state)
        S_IDLE: begin
          if (line_start) begin
            ppr_q      <= ppr_in;
            base_up    <= base_up_in;
            base_lo    <= base_lo_in;
            col        <= '0;
            half       <= 1'b0;
            all_issued <= 1'b0;
            pairs_rx   <= '0;
            word_sel   <= 1'b0;
            busy       <= 1'b1;
            state <= (ppr_in == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (accept && all_issued) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_ok) state <= S_DONE;
        end
        S_DONE: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          line_done <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_line_fetcher.sv
// Directed self-checking bench for pixel_line_fetcher.
// Arbiter modelled with 2-cycle latency; data word = its address.
module tb_pixel_line_fetcher;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        line_start;
  logic [4:0]  line_index;
  logic        frame_buffer_select;
  logic [9:0]  pixels_per_row;
  logic [14:0] address_mem;
  logic        wr_mem;
  logic        req_mem;
  logic        fifo_full_mem;
  logic [15:0] data_in_mem;
  logic        data_in_ready_mem;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        busy;
  logic        line_done;
  logic        start_ignored;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ign_cnt = 0;

  logic [14:0] acc_q[$];
  logic [31:0] pair_q[$];
  logic [14:0] pipe_addr[$];
  int          pipe_due[$];

  logic        prev_stall = 1'b0;
  logic [31:0] prev_pix = '0;
  logic        prev_hold = 1'b0;
  logic [14:0] prev_addr = '0;

  pixel_line_fetcher #(
    .FB_OFFSET (16384)
  ) dut (
    .clk_sys             (clk_sys),
    .reset               (reset),
    .line_start          (line_start),
    .line_index          (line_index),
    .frame_buffer_select (frame_buffer_select),
    .pixels_per_row      (pixels_per_row),
    .address_mem         (address_mem),
    .wr_mem              (wr_mem),
    .req_mem             (req_mem),
    .fifo_full_mem       (fifo_full_mem),
    .data_in_mem         (data_in_mem),
    .data_in_ready_mem   (data_in_ready_mem),
    .pix_data            (pix_data),
    .pix_valid           (pix_valid),
    .pix_ready           (pix_ready),
    .busy                (busy),
    .line_done           (line_done),
    .start_ignored       (start_ignored)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  always @(negedge clk_sys) begin
    cyc++;
    if (reset) begin
      pipe_addr.delete();
      pipe_due.delete();
      data_in_ready_mem = 1'b0;
      prev_stall = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_stall) chk("pix_hold", 64'(pix_data), 64'(prev_pix));
      if (prev_hold)
        chk("req_hold", 64'({req_mem, address_mem}),
            64'({1'b1, prev_addr}));
      prev_stall = pix_valid && !pix_ready;
      prev_pix = pix_data;
      prev_hold = req_mem && fifo_full_mem;
      prev_addr = address_mem;
      if (pix_valid && pix_ready) pair_q.push_back(pix_data);
      if (line_done) done_cnt++;
      if (start_ignored) ign_cnt++;
      if (req_mem && !fifo_full_mem) begin
        acc_q.push_back(address_mem);
        pipe_addr.push_back(address_mem);
        pipe_due.push_back(cyc + 2);
      end
      if (pipe_due.size() > 0 && pipe_due[0] == cyc) begin
        data_in_ready_mem = 1'b1;
        data_in_mem = {1'b0, pipe_addr[0]};
        void'(pipe_addr.pop_front());
        void'(pipe_due.pop_front());
      end else begin
        data_in_ready_mem = 1'b0;
      end
    end
  end

  task automatic start_line(
    input logic [4:0] li,
    input logic       fb,
    input logic [9:0] ppr
  );
    line_index = li;
    frame_buffer_select = fb;
    pixels_per_row = ppr;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int d;
    int n;
    d = done_cnt;
    n = 0;
    while (done_cnt == d && n < maxc) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(done_cnt != d), 64'd1);
    repeat (3) tick();
  endtask

  task automatic chk_line(
    input string tag,
    input int    ub,
    input int    lb,
    input int    n
  );
    int bad;
    logic [15:0] eu;
    logic [15:0] el;
    bad = 0;
    chk({tag, "_nreq"}, 64'(acc_q.size()), 64'(2 * n));
    chk({tag, "_npair"}, 64'(pair_q.size()), 64'(n));
    if (acc_q.size() == 2 * n && pair_q.size() == n) begin
      for (int i = 0; i < n; i++) begin
        eu = 16'((ub + i) & 32767);
        el = 16'((lb + i) & 32767);
        if ({1'b0, acc_q[2*i]} !== eu) bad++;
        if ({1'b0, acc_q[2*i+1]} !== el) bad++;
        if (pair_q[i] !== {eu, el}) bad++;
      end
    end else begin
      bad = 1;
    end
    chk({tag, "_order"}, 64'(bad), 64'd0);
    acc_q.delete();
    pair_q.delete();
  endtask

  initial begin
    int d0;
    int i0;
    int sz0;
    reset = 1'b1;
    line_start = 1'b0;
    line_index = '0;
    frame_buffer_select = 1'b0;
    pixels_per_row = '0;
    fifo_full_mem = 1'b0;
    pix_ready = 1'b1;
    data_in_mem = '0;
    data_in_ready_mem = 1'b0;
    repeat (3) tick();
    chk("rst_ctl",
        64'({req_mem, wr_mem, pix_valid, busy,
             line_done, start_ignored}), 64'd0);
    chk("rst_addr", 64'(address_mem), 64'd0);
    chk("rst_pix", 64'(pix_data), 64'd0);
    reset = 1'b0;
    tick();

    d0 = done_cnt;
    i0 = ign_cnt;
    start_line(5'd3, 1'b0, 10'd4);
    tick();
    line_index = 5'd9;
    pixels_per_row = 10'd2;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    wait_done(300);
    chk_line("basic", 12, 140, 4);
    chk("basic_pulses", 64'(done_cnt - d0), 64'd1);
    chk("ignored", 64'(ign_cnt - i0), 64'd1);
    chk("basic_idle", 64'(busy), 64'd0);

    start_line(5'd1, 1'b0, 10'd8);
    repeat (3) tick();
    fifo_full_mem = 1'b1;
    sz0 = acc_q.size();
    repeat (5) tick();
    chk("bp_frozen", 64'(acc_q.size()), 64'(sz0));
    chk("bp_req", 64'(req_mem), 64'd1);
    fifo_full_mem = 1'b0;
    wait_done(300);
    chk_line("bp", 8, 264, 8);

    pix_ready = 1'b0;
    start_line(5'd0, 1'b0, 10'd64);
    repeat (100) tick();
    chk("stall_words", 64'(acc_q.size()), 64'd16);
    chk("stall_state", 64'({pix_valid, busy}), 64'b11);
    pix_ready = 1'b1;
    wait_done(2000);
    chk_line("stall", 0, 2048, 64);

    line_index = 5'd4;
    frame_buffer_select = 1'b0;
    pixels_per_row = 10'd0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    chk("zero_c1", 64'({line_done, busy}), 64'b01);
    tick();
    chk("zero_c2", 64'({line_done, busy}), 64'b10);
    tick();
    chk("zero_c3", 64'({line_done, busy}), 64'b00);
    repeat (3) tick();
    chk("zero_noreq", 64'(acc_q.size()), 64'd0);

    start_line(5'd0, 1'b0, 10'd1023);
    wait_done(5000);
    chk_line("clamp", 0, 16384, 512);

    start_line(5'd2, 1'b1, 10'd4);
    wait_done(300);
    chk_line("fb", 16392, 16520, 4);

    start_line(5'd31, 1'b0, 10'd512);
    wait_done(5000);
    chk_line("wrap", 15872, 32256, 512);

    start_line(5'd31, 1'b1, 10'd512);
    wait_done(5000);
    chk_line("wrap_fb", 32256, 15872, 512);

    pix_ready = 1'b0;
    start_line(5'd0, 1'b0, 10'd8);
    repeat (40) tick();
    chk("drain_busy", 64'({busy, pix_valid}), 64'b11);
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    chk("midrst_out",
        64'({req_mem, pix_valid, busy, line_done,
             start_ignored, address_mem, pix_data}), 64'd0);
    reset = 1'b0;
    pix_ready = 1'b1;
    repeat (10) tick();
    chk("midrst_nodone", 64'(done_cnt - d0), 64'd0);
    chk("midrst_empty", 64'({pix_valid, busy}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
